// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: funct3 access-size codes, responder FSM states and misalignment check
package rv32_mem_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  // size[2] only selects signedness, which the CPU handles; size[1] set means word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size[1] ? |off : (size == SZ_H[1:0]) & off[0];
  endfunction
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: CPU load/store request/acknowledge bus
interface ram_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  size;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  modport master (output req, we, addr, wdata, size, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, size, output rdata, ack, err);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte strobes, lane-replicated store word and LSB-aligned raw load data
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb,
  output logic [31:0] wword,
  output logic [31:0] rdata
);
  logic        is_b, is_h;
  logic [1:0]  eff;
  logic [31:0] sh;
  assign is_b  = size == SZ_B[1:0];
  assign is_h  = size == SZ_H[1:0];
  // misaligned halves/words are forced onto their natural boundary
  assign eff   = is_b ? off : is_h ? {off[1], 1'b0} : 2'b00;
  assign strb  = is_b ? 4'b0001 << eff : is_h ? 4'b0011 << eff : 4'b1111;
  assign wword = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
  assign sh    = rword >> {eff, 3'b000};
  assign rdata = is_b ? {24'd0, sh[7:0]} : is_h ? {16'd0, sh[15:0]} : sh;
endmodule

// File: rtl/ram_responder.sv
// ram_responder: word RAM behind a req/ack load/store port with wait states; MISALIGN_TRAP_EN traps misaligned H/W
module ram_responder
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
)(
  input logic            clk,
  input logic            rs_i,
  ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t        state;
  logic [3:0]    cnt;
  logic          we_q, we_c;
  logic [AW+1:0] addr_q, addr_c;
  logic [31:0]   wdata_q, wdata_c;
  logic [1:0]    size_q, size_c;
  logic          idle, go_resp, bad, ack, err;
  logic [31:0]   rdata, ld_data, wword;
  logic [3:0]    strb;
  logic [31:0]   mem [DEPTH_WORDS];
  assign idle    = state == ST_IDLE;
  // in IDLE the live bus is used so a zero-wait access can complete on its acceptance edge
  assign we_c    = idle ? bus.we : we_q;
  assign addr_c  = idle ? bus.addr[AW+1:0] : addr_q;
  assign wdata_c = idle ? bus.wdata : wdata_q;
  assign size_c  = idle ? bus.size[1:0] : size_q;
  assign go_resp = idle ? bus.req && WAIT_CYCLES == 0 : state == ST_WAIT && cnt == 4'd0;
`ifdef MISALIGN_TRAP_EN
  assign bad = misaligned(size_c, addr_c[1:0]);
`else
  assign bad = 1'b0;
`endif
  mem_lane_align u_align (
    .size  (size_c),
    .off   (addr_c[1:0]),
    .wdata (wdata_c),
    .rword (mem[addr_c[AW+1:2]]),
    .strb  (strb),
    .wword (wword),
    .rdata (ld_data)
  );
  assign bus.ack   = ack;
  assign bus.err   = err;
  assign bus.rdata = rdata;
  // request FSM: capture, count wait states, pulse ack with registered load data
  always_ff @(posedge clk) begin
    if (!rs_i) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= go_resp;
      err <= go_resp & bad;
      if (go_resp) rdata <= (we_c | bad) ? '0 : ld_data;
      case (state)
        ST_IDLE: if (bus.req) begin
          we_q    <= bus.we;
          addr_q  <= bus.addr[AW+1:0];
          wdata_q <= bus.wdata;
          size_q  <= bus.size[1:0];
          cnt     <= 4'(WAIT_CYCLES);
          state   <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: if (cnt == 4'd0) state <= ST_RESP; else cnt <= cnt - 4'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end
  // store commit on the edge entering RESP, enabled lanes only; a reset edge never writes
  always_ff @(posedge clk) begin
    if (rs_i && go_resp && we_c && !bad)
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem[addr_c[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed load/store checks on a 2-wait-state and a 0-wait-state responder
module tb_ram_responder;
  import rv32_mem_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        we = 1'b0, req2 = 1'b0, req0 = 1'b0, sel = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  size = SZ_W;
  logic        ack_s, err_s;
  logic [31:0] rdata_s;
  int          checks = 0, errors = 0;
  ram_responder_if bus2();
  ram_responder_if bus0();
  assign bus2.req = req2;
  assign bus2.we = we;
  assign bus2.addr = addr;
  assign bus2.wdata = wdata;
  assign bus2.size = size;
  assign bus0.req = req0;
  assign bus0.we = we;
  assign bus0.addr = addr;
  assign bus0.wdata = wdata;
  assign bus0.size = size;
  assign ack_s   = sel ? bus0.ack : bus2.ack;
  assign err_s   = sel ? bus0.err : bus2.err;
  assign rdata_s = sel ? bus0.rdata : bus2.rdata;
  ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rs_i(rst_n), .bus(bus2));
  ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rs_i(rst_n), .bus(bus0));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one transaction; lat counts edges from acceptance to the edge raising ack
  task automatic access(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    sel = s; we = w; addr = a; wdata = d; size = sz;
    if (s) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    lat = 0; rd = '0; e = 1'b0;
    while (1) begin
      #1;
      if (ack_s) begin
        rd = rdata_s;
        e = err_s;
        break;
      end
      if (lat == 20) begin
        check("ack_timeout", {31'd0, ack_s}, 32'd1);
        break;
      end
      @(posedge clk);
      lat++;
    end
    req0 = 1'b0;
    req2 = 1'b0;
    @(posedge clk);
  endtask
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, bus2.ack}, 32'd0);
    check("rst_err", {31'd0, bus2.err}, 32'd0);
    check("rst_rdata", bus2.rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    access(0, 1, 32'h10, 32'hDEADBEEF, SZ_W, rd, e, lat);
    check("st_w_lat", lat, 32'd3);
    check("st_w_err", {31'd0, e}, 32'd0);
    check("st_w_rdata", rd, 32'd0);
    access(0, 0, 32'h10, 32'h0, SZ_W, rd, e, lat);
    check("ld_w_lat", lat, 32'd3);
    check("ld_w", rd, 32'hDEADBEEF);
    access(0, 1, 32'h10, 32'h11223344, SZ_W, rd, e, lat);
    access(0, 1, 32'h13, 32'h123456AA, SZ_B, rd, e, lat);
    access(0, 0, 32'h10, 32'h0, SZ_W, rd, e, lat);
    check("st_b_word", rd, 32'hAA223344);
    access(0, 0, 32'h13, 32'h0, SZ_B, rd, e, lat);
    check("ld_b", rd, 32'h000000AA);
    access(0, 0, 32'h13, 32'h0, SZ_BU, rd, e, lat);
    check("ld_bu", rd, 32'h000000AA);
    access(0, 1, 32'h12, 32'hFFFF5566, SZ_H, rd, e, lat);
    access(0, 0, 32'h10, 32'h0, SZ_W, rd, e, lat);
    check("st_h_word", rd, 32'h55663344);
    access(0, 0, 32'h12, 32'h0, SZ_HU, rd, e, lat);
    check("ld_hu", rd, 32'h00005566);
    access(0, 0, 32'h12, 32'h0, SZ_H, rd, e, lat);
    check("ld_h", rd, 32'h00005566);
    access(0, 1, 32'h20, 32'hCAFEF00D, SZ_W, rd, e, lat);
    @(negedge clk);
    sel = 0; we = 1; addr = 32'h20; wdata = 32'h0; size = SZ_W; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req2 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus2.ack) n++;
    end
    check("rst_mid_noack", n, 32'd0);
    access(0, 0, 32'h20, 32'h0, SZ_W, rd, e, lat);
    check("rst_mid_nowrite", rd, 32'hCAFEF00D);
    access(0, 1, 32'h22, 32'h12345678, SZ_W, rd, e, lat);
    check("mis_rdata", rd, 32'd0);
    check("mis_lat", lat, 32'd3);
`ifdef MISALIGN_TRAP_EN
    check("mis_err", {31'd0, e}, 32'd1);
    access(0, 0, 32'h20, 32'h0, SZ_W, rd, e, lat);
    check("mis_ram", rd, 32'hCAFEF00D);
`else
    check("mis_err", {31'd0, e}, 32'd0);
    access(0, 0, 32'h20, 32'h0, SZ_W, rd, e, lat);
    check("mis_ram", rd, 32'h12345678);
`endif
    access(1, 1, 32'h1000, 32'h0BADF00D, SZ_W, rd, e, lat);
    check("w0_st_lat", lat, 32'd0);
    access(1, 0, 32'h0, 32'h0, SZ_W, rd, e, lat);
    check("w0_wrap", rd, 32'h0BADF00D);
    check("w0_ld_lat", lat, 32'd0);
    @(negedge clk);
    sel = 1; we = 0; addr = 32'h0; size = SZ_W; req0 = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus0.ack) n++;
    end
    req0 = 1'b0;
    check("b2b_acks", n, 32'd3);
    check("b2b_rdata", bus0.rdata, 32'h0BADF00D);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
